// File: rtl/fila_fifo.sv
// fila_fifo: small circular-buffer FIFO for low-rate control logic.
//
// Enqueue and dequeue requests are edge-triggered. A request counts once, on
// its 0->1 transition, however long it is then held high. The last dequeued
// byte and the current occupancy are held in registers and exported.
//
// Ports:
//   clk_10KHz   in   1       system clock, all state changes on rising edge
//   reset       in   1       synchronous, active-low reset
//   data_in     in   DATA_W  byte stored on an enqueue event
//   enqueue_in  in   1       enqueue request (acted on at its rising transition)
//   dequeue_in  in   1       dequeue request (acted on at its rising transition)
//   data_out    out  DATA_W  last dequeued byte, held until the next dequeue
//   len_out     out  LEN_W   number of entries currently stored (0..DEPTH)

module fila_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0] FULL_LEN  = LEN_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              enq_prev;
  logic              deq_prev;

  logic              enq_evt;
  logic              deq_evt;
  logic              is_full;
  logic              is_empty;
  logic              do_enq;
  logic              do_deq;
  logic [PTR_W-1:0]  head_next;
  logic [PTR_W-1:0]  tail_next;
  logic [LEN_W-1:0]  len_next;

  // Pointers wrap explicitly at DEPTH-1 so a non power-of-two depth still
  // behaves as a true modulo-DEPTH ring.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Request decoding and the occupancy update.
  // The dequeue is decided first; on a full queue a simultaneous dequeue
  // frees a slot, so the enqueue is also accepted and the count stays at
  // DEPTH. On an empty queue the dequeue is dropped and only the enqueue
  // takes effect.
  always_comb begin
    enq_evt   = enqueue_in & ~enq_prev;
    deq_evt   = dequeue_in & ~deq_prev;
    is_full   = (len_out == FULL_LEN);
    is_empty  = (len_out == '0);
    do_deq    = deq_evt & ~is_empty;
    do_enq    = enq_evt & (~is_full | do_deq);
    head_next = head;
    tail_next = tail;
    len_next  = len_out;

    if (do_deq) begin
      head_next = ptr_inc(head);
    end
    if (do_enq) begin
      tail_next = ptr_inc(tail);
    end

    case ({do_enq, do_deq})
      2'b10:   len_next = len_out + LEN_W'(1);
      2'b01:   len_next = len_out - LEN_W'(1);
      default: len_next = len_out;
    endcase
  end

  // Control state: pointers, count, output byte and request history.
  // The history registers also clear on reset, so a request that is
  // already high when reset releases counts as an event on the first edge.
  always_ff @(posedge clk_10KHz) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      len_out  <= '0;
      data_out <= '0;
      enq_prev <= 1'b0;
      deq_prev <= 1'b0;
    end else begin
      enq_prev <= enqueue_in;
      deq_prev <= dequeue_in;
      head     <= head_next;
      tail     <= tail_next;
      len_out  <= len_next;
      if (do_deq) begin
        data_out <= mem[head];
      end
    end
  end

  // Storage has no reset; stale contents are unreachable once the pointers
  // and the count have been cleared. When full with a simultaneous dequeue,
  // head == tail: the read above sees the old byte before this write lands.
  always_ff @(posedge clk_10KHz) begin
    if (reset && do_enq) begin
      mem[tail] <= data_in;
    end
  end

endmodule

// File: tb/tb_fila_fifo.sv
// tb_fila_fifo: self-checking bench for fila_fifo.
// A queue-based reference model tracks the expected byte stream and count.
// Directed sequences cover reset, fill/overflow, drain/underflow, held
// requests, pointer wrap and simultaneous requests. Randomized traffic
// follows them.

module tb_fila_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 8;

  logic              clk_10KHz;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              enqueue_in;
  logic              dequeue_in;
  logic [DATA_W-1:0] data_out;
  logic [LEN_W-1:0]  len_out;

  int checks;
  int errors;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_data;
  logic              model_enq_prev;
  logic              model_deq_prev;

  fila_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .data_in   (data_in),
    .enqueue_in(enqueue_in),
    .dequeue_in(dequeue_in),
    .data_out  (data_out),
    .len_out   (len_out)
  );

  initial clk_10KHz = 1'b0;
  always #5 clk_10KHz = ~clk_10KHz;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model by the rules of
  // the queue, then compare both outputs shortly after the rising edge.
  task automatic applyStimulus(input logic rst_n, input logic enq,
                               input logic deq, input logic [DATA_W-1:0] din);
    logic enq_edge;
    logic deq_edge;
    @(negedge clk_10KHz);
    reset      = rst_n;
    enqueue_in = enq;
    dequeue_in = deq;
    data_in    = din;

    if (!rst_n) begin
      model_q.delete();
      model_data     = '0;
      model_enq_prev = 1'b0;
      model_deq_prev = 1'b0;
    end else begin
      enq_edge = enq && !model_enq_prev;
      deq_edge = deq && !model_deq_prev;
      if (deq_edge && model_q.size() > 0) begin
        model_data = model_q.pop_front();
      end
      if (enq_edge && model_q.size() < DEPTH) begin
        model_q.push_back(din);
      end
      model_enq_prev = enq;
      model_deq_prev = deq;
    end

    @(posedge clk_10KHz);
    #1;
    checkOutput("data_out", 32'(data_out), 32'(model_data));
    checkOutput("len_out", 32'(len_out), 32'(model_q.size()));
  endtask

  task automatic pulseEnq(input logic [DATA_W-1:0] din);
    applyStimulus(1'b1, 1'b1, 1'b0, din);
    applyStimulus(1'b1, 1'b0, 1'b0, din);
  endtask

  task automatic pulseDeq();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [DATA_W-1:0] expect_byte;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    data_in    = '0;
    model_data     = '0;
    model_enq_prev = 1'b0;
    model_deq_prev = 1'b0;

    // Reset, then a dequeue on an empty queue.
    doReset();
    checkOutput("reset_len", 32'(len_out), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    pulseDeq();
    checkOutput("empty_deq_len", 32'(len_out), 32'd0);
    checkOutput("empty_deq_data", 32'(data_out), 32'd0);

    // Fill with 11..88, then overflow with 99.
    for (int i = 1; i <= DEPTH; i++) begin
      pulseEnq(8'(i * 8'h11));
      checkOutput("fill_len", 32'(len_out), 32'(i));
    end
    pulseEnq(8'h99);
    checkOutput("overflow_len", 32'(len_out), 32'd8);

    // Drain with dequeue requests held 5 cycles; the ninth underflows.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      for (int c = 0; c < 5; c++) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      expect_byte = (i <= DEPTH) ? 8'(i * 8'h11) : 8'h88;
      checkOutput("drain_data", 32'(data_out), 32'(expect_byte));
      checkOutput("drain_len", 32'(len_out), (i <= DEPTH) ? 32'(DEPTH - i) : 32'd0);
    end

    // A held enqueue request stores exactly one entry.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
    checkOutput("held_enq_len", 32'(len_out), 32'd1);
    pulseDeq();
    checkOutput("held_enq_data", 32'(data_out), 32'hAA);

    // Pointer wrap: 5 in/out, then 6 more across the wrap point.
    for (int i = 0; i < 5; i++) pulseEnq(8'(8'hB0 + i));
    for (int i = 0; i < 5; i++) pulseDeq();
    for (int i = 0; i < 6; i++) pulseEnq(8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) begin
      pulseDeq();
      checkOutput("wrap_data", 32'(data_out), 32'(8'hA0 + i));
    end
    checkOutput("wrap_len", 32'(len_out), 32'd0);

    // Simultaneous requests at partial fill.
    doReset();
    pulseEnq(8'h31);
    pulseEnq(8'h32);
    pulseEnq(8'h33);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h34);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("simul_data", 32'(data_out), 32'h31);
    checkOutput("simul_len", 32'(len_out), 32'd3);

    // Simultaneous requests when empty: enqueue only.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("simul_empty_len", 32'(len_out), 32'd1);
    checkOutput("simul_empty_data", 32'(data_out), 32'd0);

    // Simultaneous requests when full: count stays at DEPTH.
    doReset();
    for (int i = 0; i < DEPTH; i++) pulseEnq(8'(8'hC0 + i));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hCF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("simul_full_len", 32'(len_out), 32'd8);
    checkOutput("simul_full_data", 32'(data_out), 32'hC0);

    // Reset with 5 entries stored.
    doReset();
    for (int i = 0; i < 5; i++) pulseEnq(8'(8'hD0 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("midreset_len", 32'(len_out), 32'd0);

    // Request already high as reset releases counts on the first edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hE7);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hE7);
    checkOutput("post_reset_enq_len", 32'(len_out), 32'd1);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int phase = 0; phase < 8; phase++) begin
      for (int c = 0; c < 200; c++) begin
        logic r, e, d;
        r = ($urandom_range(0, 199) != 0);
        if (phase[0]) begin
          e = ($urandom_range(0, 9) < 7);
          d = ($urandom_range(0, 9) < 3);
        end else begin
          e = ($urandom_range(0, 9) < 3);
          d = ($urandom_range(0, 9) < 7);
        end
        applyStimulus(r, e, d, 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
